// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: opcode map, immediate format enum and data width for the immediate generator
package imm_gen_pkg;
    localparam int IMM_W = 16;
    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LW   = 4'h2;
    localparam logic [3:0] OP_SW   = 4'h3;
    localparam logic [3:0] OP_LUI  = 4'h4;
    localparam logic [3:0] OP_ORI  = 4'h5;
    localparam logic [3:0] OP_BEQ  = 4'h6;
    localparam logic [3:0] OP_BNE  = 4'h7;
    localparam logic [3:0] OP_BLT  = 4'h8;
    localparam logic [3:0] OP_JAL  = 4'h9;
    localparam logic [3:0] OP_JALR = 4'hA;
    localparam logic [3:0] OP_SLLI = 4'hB;
    localparam logic [3:0] OP_SRLI = 4'hC;
    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_U, FMT_Z, FMT_B, FMT_J, FMT_S, FMT_NONE
    } imm_fmt_t;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational opcode-to-immediate-format decoder
module imm_decode
    import imm_gen_pkg::*;
(
    input  logic [3:0] op,
    output imm_fmt_t   fmt
);
    always_comb begin
        fmt = FMT_NONE;
        case (op)
            OP_R:                         fmt = FMT_R;
            OP_ADDI, OP_LW, OP_SW, OP_JALR: fmt = FMT_I;
            OP_LUI:                       fmt = FMT_U;
            OP_ORI:                       fmt = FMT_Z;
            OP_BEQ, OP_BNE, OP_BLT:       fmt = FMT_B;
            OP_JAL:                       fmt = FMT_J;
            OP_SLLI, OP_SRLI:             fmt = FMT_S;
            default:                      fmt = FMT_NONE;
        endcase
    end
endmodule

// File: rtl/imm_gen_component.sv
// imm_gen_component: decodes the instruction format and registers the extended/shifted immediate
module imm_gen_component
    import imm_gen_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [IMM_W-1:0] inst,
    output logic [IMM_W-1:0] out
);
    imm_fmt_t         fmt;
    logic [IMM_W-1:0] imm;

    imm_decode u_decode (.op(inst[3:0]), .fmt(fmt));

    // each arm reads only its own field, so unused bits cannot leak into out
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{8{inst[15]}}, inst[15:8]};
            FMT_U:   imm = {inst[15:8], 8'h00};
            FMT_Z:   imm = {8'h00, inst[15:8]};
            FMT_B:   imm = {{7{inst[15]}}, inst[15:8], 1'b0};
            FMT_J:   imm = {{3{inst[15]}}, inst[15:4], 1'b0};
            FMT_S:   imm = {12'h000, inst[15:12]};
            default: imm = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) out <= '0;
        else       out <= imm;
endmodule

// File: tb/tb_imm_gen_component.sv
// tb_imm_gen_component: directed-vector self-checking bench for imm_gen_component
module tb_imm_gen_component;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] inst  = 16'h0000;
    logic [15:0] out;
    int checks = 0;
    int passed = 0;

    imm_gen_component dut (.clock(clock), .reset(reset), .inst(inst), .out(out));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] exp);
        checks++;
        assert (out === exp) passed++;
        else $error("FAIL %s: out=%h expected=%h", tag, out, exp);
    endtask

    task automatic step(input string tag, input logic [15:0] v, input logic [15:0] exp);
        @(negedge clock);
        inst = v;
        @(posedge clock);
        #1;
        check(tag, exp);
    endtask

    initial begin
        inst = 16'h9696;
        #2 reset = 1'b1;
        #1 check("reset_async", 16'h0000);
        @(posedge clock); #1 check("reset_hold1", 16'h0000);
        @(negedge clock) inst = 16'h7F01;
        @(posedge clock); #1 check("reset_hold2", 16'h0000);
        @(negedge clock) reset = 1'b0;

        step("beq_neg",   16'h9696, 16'hFF2C);
        step("bne_pos",   16'h7F07, 16'h00FE);
        step("blt_min",   16'h8008, 16'hFF00);
        step("addi_pos",  16'h7F01, 16'h007F);
        step("addi_neg",  16'h8001, 16'hFF80);
        step("lw",        16'h0502, 16'h0005);
        step("sw_m1",     16'hFF03, 16'hFFFF);
        step("jalr_neg",  16'h800A, 16'hFF80);
        step("lui",       16'hAB04, 16'hAB00);
        step("ori",       16'h8005, 16'h0080);
        step("jal_neg",   16'h8009, 16'hF000);
        step("jal_pos",   16'h0129, 16'h0024);
        step("slli",      16'h520B, 16'h0005);
        step("srli",      16'hF00C, 16'h000F);
        step("rsv_f",     16'hFFFF, 16'h0000);
        step("rsv_d",     16'hABCD, 16'h0000);
        step("r_type",    16'hFFF0, 16'h0000);

        step("mid_beq",   16'h9696, 16'hFF2C);
        @(negedge clock) reset = 1'b1;
        #1 check("mid_async_clear", 16'h0000);
        @(posedge clock); #1 check("mid_hold", 16'h0000);
        @(negedge clock) reset = 1'b0;
        @(posedge clock); #1 check("mid_recover", 16'hFF2C);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
